// File: rtl/pattern_generator_if.sv
// Control and stream bundle for pattern_generator.
// master: drives tick/start/mode/load/pat_in, observes the stream and status.
// slave : the generator itself.
interface pattern_generator_if #(
  parameter int unsigned PAT_LEN = 6
);
  logic               tick;
  logic               start;
  logic               mode;
  logic               load;
  logic [PAT_LEN-1:0] pat_in;
  logic               X;
  logic               valid;
  logic               busy;
  logic               done;
  logic [3:0]         bit_idx;
  logic [7:0]         frames;

  modport master (
    output tick, start, mode, load, pat_in,
    input  X, valid, busy, done, bit_idx, frames
  );

  modport slave (
    input  tick, start, mode, load, pat_in,
    output X, valid, busy, done, bit_idx, frames
  );
endinterface

// File: rtl/pattern_generator.sv
// Serial bit-pattern transmitter: shifts a PAT_LEN-bit pattern out MSB first,
// one bit per tick, in single-frame or continuous mode with an optional
// GAP-tick idle stretch between repetitions. Counts completed frames.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - pattern_generator_if.slave: tick/start/mode/load/pat_in in,
//           X/valid/busy/done/bit_idx/frames out (all registered)
module pattern_generator #(
  parameter int unsigned        PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(6'b101101),
  parameter int unsigned        GAP     = 0
) (
  input  logic                clk,
  input  logic                reset,
  pattern_generator_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(PAT_LEN - 1);
  // Only reachable when GAP > 0; the wrapped value for GAP = 0 is never used.
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t             state_q, state_n;
  logic [PAT_LEN-1:0] pat_q, pat_n;
  logic [PAT_LEN-1:0] sh_q, sh_n;
  logic               x_q, x_n;
  logic               valid_q, valid_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [3:0]         idx_q, idx_n;
  logic [7:0]         frames_q, frames_n;
  logic [3:0]         gap_q, gap_n;
  logic [PAT_LEN-1:0] frame_pat;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pat_q    <= PATTERN;
      sh_q     <= '0;
      x_q      <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= 4'd0;
      frames_q <= 8'd0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_n;
      pat_q    <= pat_n;
      sh_q     <= sh_n;
      x_q      <= x_n;
      valid_q  <= valid_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      idx_q    <= idx_n;
      frames_q <= frames_n;
      gap_q    <= gap_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_q;
    pat_n     = pat_q;
    sh_n      = sh_q;
    x_n       = x_q;
    valid_n   = valid_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    idx_n     = idx_q;
    frames_n  = frames_q;
    gap_n     = gap_q;
    // A load in the start cycle must take effect for that very frame.
    frame_pat = bus.load ? bus.pat_in : pat_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          pat_n = bus.pat_in;
        end
        // tick is deliberately ignored here so the MSB gets a full tick period
        if (bus.start) begin
          state_n = ST_SEND;
          sh_n    = frame_pat;
          x_n     = frame_pat[PAT_LEN-1];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          idx_n   = 4'd0;
        end
      end

      ST_SEND: begin
        if (bus.tick) begin
          if (idx_q != LAST_IDX) begin
            // sh_q holds the frame aligned so that its MSB is the bit on X
            idx_n = idx_q + 4'd1;
            sh_n  = sh_q << 1;
            x_n   = sh_q[PAT_LEN-2];
          end else begin
            frames_n = frames_q + 8'd1;
            done_n   = 1'b1;
            idx_n    = 4'd0;
            if (!bus.mode) begin
              state_n = ST_IDLE;
              x_n     = 1'b0;
              valid_n = 1'b0;
              busy_n  = 1'b0;
            end else if (GAP == 0) begin
              sh_n = pat_q;
              x_n  = pat_q[PAT_LEN-1];
            end else begin
              state_n = ST_GAP;
              x_n     = 1'b0;
              valid_n = 1'b0;
              gap_n   = 4'd0;
            end
          end
        end
      end

      ST_GAP: begin
        // Counter value k means k gap ticks already seen; leave after GAP ticks.
        if (bus.tick) begin
          if (gap_q == GAP_LAST) begin
            state_n = ST_SEND;
            sh_n    = pat_q;
            x_n     = pat_q[PAT_LEN-1];
            valid_n = 1'b1;
            idx_n   = 4'd0;
          end else begin
            gap_n = gap_q + 4'd1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.X       = x_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_idx = idx_q;
  assign bus.frames  = frames_q;

endmodule
